// File: rtl/spi_slave.sv
// SPI peripheral endpoint: oversamples SCK/CSn/MOSI in the clk domain, deserialises MOSI and serialises a TX byte per slot.
// Optional macro SPI_SLAVE_LSB_FIRST_EN switches both directions to LSB-first (default MSB-first).
module spi_slave #(
   parameter int         SPI_MODE         = 0,
   parameter int         MAX_BYTES_PER_CS = 2,
   parameter logic [7:0] DEFAULT_TX_BYTE  = 8'hFF,
   localparam int        CW               = $clog2(MAX_BYTES_PER_CS + 1)
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          i_SCK,
   input  logic          i_CSn,
   input  logic          i_MOSI,
   output logic          o_MISO,
   output logic          o_MISO_OE,
   input  logic [7:0]    i_TX_Byte,
   input  logic          i_TX_DV,
   output logic          o_TX_Ready,
   output logic          o_TX_Underrun,
   output logic          o_RX_DV,
   output logic [7:0]    o_RX_Byte,
   output logic [CW-1:0] o_RX_Count,
   output logic          o_CS_Active
);

   localparam logic          CPOL    = ((SPI_MODE / 2) % 2) != 0;
   localparam logic          CPHA    = (SPI_MODE % 2) != 0;
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BYTES_PER_CS);

   typedef enum logic {IDLE, ACTIVE} state_t;
   state_t state_q, state_d;

   logic sck_s1_q, sck_s1_d, sck_s2_q, sck_s2_d, sck_dly_q, sck_dly_d;
   logic csn_s1_q, csn_s1_d, csn_s2_q, csn_s2_d;
   logic mosi_s1_q, mosi_s1_d, mosi_s2_q, mosi_s2_d;
   logic [1:0] settle_q, settle_d;
   logic armed_q, armed_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] rx_sr_q, rx_sr_d, rx_byte_q, rx_byte_d, tx_sr_q, tx_sr_d, hold_q, hold_d;
   logic rx_dv_q, rx_dv_d, miso_q, miso_d, hold_full_q, hold_full_d;
   logic tx_ready_q, tx_ready_d, underrun_q, underrun_d;
   logic [CW-1:0] rx_count_q, rx_count_d;
   logic sck_lead, sck_trail, sample_edge, shift_edge;
   logic cs_active, frame_start, frame_end, load, wr;
   logic [7:0] load_byte, rx_shift, tx_shift;

   function automatic logic lead_bit(input logic [7:0] b);
`ifdef SPI_SLAVE_LSB_FIRST_EN
      return b[0];
`else
      return b[7];
`endif
   endfunction

   assign sck_lead    = (sck_s2_q != CPOL) && (sck_dly_q == CPOL);
   assign sck_trail   = (sck_s2_q == CPOL) && (sck_dly_q != CPOL);
   assign sample_edge = CPHA ? sck_trail : sck_lead;
   assign shift_edge  = CPHA ? sck_lead : sck_trail;

   always_ff @(posedge clk) begin
      if (!rstn) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // armed_q blocks joining a frame whose CSn was already low when reset released
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (armed_q && !csn_s2_q) state_d = ACTIVE;
         ACTIVE:  if (csn_s2_q) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cs_active   = (state_q == ACTIVE);
      frame_start = (state_q == IDLE) && armed_q && !csn_s2_q;
      frame_end   = (state_q == ACTIVE) && csn_s2_q;
   end

   always_comb begin
      sck_s1_d    = i_SCK;
      sck_s2_d    = sck_s1_q;
      sck_dly_d   = sck_s2_q;
      csn_s1_d    = i_CSn;
      csn_s2_d    = csn_s1_q;
      mosi_s1_d   = i_MOSI;
      mosi_s2_d   = mosi_s1_q;
      settle_d    = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
      armed_d     = armed_q | ((settle_q == 2'd3) & csn_s2_q);
      bit_cnt_d   = bit_cnt_q;
      rx_sr_d     = rx_sr_q;
      rx_byte_d   = rx_byte_q;
      rx_dv_d     = 1'b0;
      rx_count_d  = rx_count_q;
      tx_sr_d     = tx_sr_q;
      miso_d      = miso_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      underrun_d  = 1'b0;
      load        = 1'b0;
      load_byte   = DEFAULT_TX_BYTE;
      wr          = i_TX_DV & tx_ready_q;
`ifdef SPI_SLAVE_LSB_FIRST_EN
      rx_shift    = {mosi_s2_q, rx_sr_q[7:1]};
      tx_shift    = {1'b0, tx_sr_q[7:1]};
`else
      rx_shift    = {rx_sr_q[6:0], mosi_s2_q};
      tx_shift    = {tx_sr_q[6:0], 1'b0};
`endif
      if (rx_dv_q && (rx_count_q != CNT_MAX)) rx_count_d = rx_count_q + CW'(1);
      if (frame_start) begin
         bit_cnt_d  = 3'd0;
         rx_count_d = '0;
         load       = !CPHA;
      end else if (frame_end) begin
         bit_cnt_d = 3'd0;
      end else if (cs_active) begin
         if (sample_edge) begin
            rx_sr_d   = rx_shift;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
               rx_byte_d = rx_shift;
               rx_dv_d   = 1'b1;
            end
         end
         // Counter at 0 on a shift edge marks a byte boundary in both CPHA settings
         if (shift_edge) begin
            if (bit_cnt_q == 3'd0) begin
               load = 1'b1;
            end else begin
               tx_sr_d = tx_shift;
               miso_d  = lead_bit(tx_shift);
            end
         end
      end
      if (wr) begin
         hold_d      = i_TX_Byte;
         hold_full_d = 1'b1;
      end
      if (load) begin
         if (hold_full_q) begin
            load_byte   = hold_q;
            hold_full_d = 1'b0;
         end else if (wr) begin
            load_byte   = i_TX_Byte;
            hold_full_d = 1'b0;
         end else begin
            underrun_d = 1'b1;
         end
         tx_sr_d = load_byte;
         miso_d  = lead_bit(load_byte);
      end
      tx_ready_d = ~hold_full_d;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         sck_s1_q    <= CPOL;
         sck_s2_q    <= CPOL;
         sck_dly_q   <= CPOL;
         csn_s1_q    <= 1'b1;
         csn_s2_q    <= 1'b1;
         mosi_s1_q   <= 1'b0;
         mosi_s2_q   <= 1'b0;
         settle_q    <= 2'd0;
         armed_q     <= 1'b0;
         bit_cnt_q   <= 3'd0;
         rx_sr_q     <= 8'h00;
         rx_byte_q   <= 8'h00;
         rx_dv_q     <= 1'b0;
         rx_count_q  <= '0;
         tx_sr_q     <= 8'h00;
         miso_q      <= 1'b0;
         hold_q      <= 8'h00;
         hold_full_q <= 1'b0;
         tx_ready_q  <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         sck_s1_q    <= sck_s1_d;
         sck_s2_q    <= sck_s2_d;
         sck_dly_q   <= sck_dly_d;
         csn_s1_q    <= csn_s1_d;
         csn_s2_q    <= csn_s2_d;
         mosi_s1_q   <= mosi_s1_d;
         mosi_s2_q   <= mosi_s2_d;
         settle_q    <= settle_d;
         armed_q     <= armed_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_sr_q     <= rx_sr_d;
         rx_byte_q   <= rx_byte_d;
         rx_dv_q     <= rx_dv_d;
         rx_count_q  <= rx_count_d;
         tx_sr_q     <= tx_sr_d;
         miso_q      <= miso_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         tx_ready_q  <= tx_ready_d;
         underrun_q  <= underrun_d;
      end
   end

   assign o_MISO        = miso_q;
   assign o_MISO_OE     = cs_active;
   assign o_CS_Active   = cs_active;
   assign o_TX_Ready    = tx_ready_q;
   assign o_TX_Underrun = underrun_q;
   assign o_RX_DV       = rx_dv_q;
   assign o_RX_Byte     = rx_byte_q;
   assign o_RX_Count    = rx_count_q;

endmodule
